// File: rtl/resonant_bank_if.sv
// resonant_bank_if: host-side bus of the resonator bank.
//   Mem1_*       : coefficient / sample write port (EMIF-fed), host -> bank
//   enable_i     : start request (rising edge runs one update), host -> bank
//   clear_i      : single-cycle request to zero all resonator states, host -> bank
//   Mem2_*       : per-element result write port, bank -> result memory
//   WIP_flag_o   : busy (run or clear in progress), bank -> host
//   done_o       : one-cycle pulse at the end of a run, bank -> host
// The master modport is the host side, the slave modport is the bank.
interface resonant_bank_if #(
  parameter int MEM1_AW = 9,
  parameter int MEM2_AW = 9,
  parameter int MEM2_DW = 36
);
  logic [31:0]         Mem1_data_i;
  logic [MEM1_AW-1:0]  Mem1_addrw_i;
  logic                Mem1_en_i;
  logic                Mem1_we_i;
  logic                enable_i;
  logic                clear_i;
  logic [MEM2_AW-1:0]  Mem2_addrw_o;
  logic                Mem2_we_o;
  logic [MEM2_DW-1:0]  Mem2_data_o;
  logic                WIP_flag_o;
  logic                done_o;

  modport master (
    output Mem1_data_i, Mem1_addrw_i, Mem1_en_i, Mem1_we_i, enable_i, clear_i,
    input  Mem2_addrw_o, Mem2_we_o, Mem2_data_o, WIP_flag_o, done_o
  );

  modport slave (
    input  Mem1_data_i, Mem1_addrw_i, Mem1_en_i, Mem1_we_i, enable_i, clear_i,
    output Mem2_addrw_o, Mem2_we_o, Mem2_data_o, WIP_flag_o, done_o
  );
endinterface

// File: rtl/resonant_bank.sv
// resonant_bank: time-multiplexed bank of second-order Goertzel resonators.
// HARMONICS_NUM resonators per channel times IN_SERIES_NUM channels share a
// single multiplier; each start runs one sample update of every element:
//   s0 = sat(x[ch] + ((coef[h] * s1) >>> FRAC) - s2);  s2 <= s1;  s1 <= s0
// and streams s0 (sign-extended) to Mem2 at address ch*H + h.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset; an auto-clear of all states
//            follows release
//   bus    : resonant_bank_if.slave (Mem1 write port, enable/clear requests,
//            Mem2 result port, WIP flag and done pulse)
module resonant_bank #(
  parameter int HARMONICS_NUM = 26,
  parameter int IN_SERIES_NUM = 6,
  parameter int DATA_W        = 18,
  parameter int COEF_W        = 18,
  parameter int STATE_W       = 32,
  parameter int MEM1_AW       = 9,
  parameter int MEM2_AW       = 9,
  parameter int MEM2_DW       = 36
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  resonant_bank_if.slave bus
);

  localparam int N    = HARMONICS_NUM * IN_SERIES_NUM;
  localparam int FRAC = COEF_W - 2;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int HW   = (HARMONICS_NUM > 1) ? $clog2(HARMONICS_NUM) : 1;
  localparam int CW   = (IN_SERIES_NUM > 1) ? $clog2(IN_SERIES_NUM) : 1;
  localparam int LW   = MEM1_AW - 1;
  localparam int PW   = COEF_W + STATE_W;
  localparam int SW   = STATE_W + 2;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  // Floor-scaled product, narrowed to the adder width. The product magnitude
  // after the shift is at most 2^STATE_W, so SW bits always hold it.
  function automatic logic signed [SW-1:0] scale_floor(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    sh = p >>> FRAC;
    return sh[SW-1:0];
  endfunction

  // Clamp an SW-bit sum into the STATE_W-bit state range.
  function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [SW-1:0] v);
    if (v[SW-1:STATE_W-1] == {3{v[SW-1]}})
      return v[STATE_W-1:0];
    else if (v[SW-1])
      return {1'b1, {(STATE_W-1){1'b0}}};
    else
      return {1'b0, {(STATE_W-1){1'b1}}};
  endfunction

  // Storage (not reset)
  logic signed [COEF_W-1:0]  coef_mem [2**HW];
  logic signed [DATA_W-1:0]  smp_mem  [2**CW];
  logic signed [STATE_W-1:0] s1_mem   [2**KW];
  logic signed [STATE_W-1:0] s2_mem   [2**KW];

  // Control
  state_t          state, state_nxt;
  logic [KW-1:0]   cnt, cnt_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [CW-1:0]   ch_cnt, ch_nxt;
  logic [1:0]      dcnt, dcnt_nxt;
  logic            init_q;
  logic            enable_q;
  logic            done_nxt;
  logic            issue;
  logic            clr_wr;
  logic            vld_p0, vld_p1;

  // Datapath
  logic signed [STATE_W-1:0] s1_p0, s2_p0, s1_p1, s2_p1;
  logic signed [COEF_W-1:0]  coef_p0;
  logic signed [DATA_W-1:0]  x_p0, x_p1;
  logic [KW-1:0]             k_p0, k_p1;
  logic signed [PW-1:0]      prod_w;
  logic signed [SW-1:0]      psh_p1;
  logic signed [SW-1:0]      sum_w;
  logic signed [STATE_W-1:0] s0_w;

  // Output registers
  logic                we_p2;
  logic [MEM2_AW-1:0]  addr_p2;
  logic [MEM2_DW-1:0]  data_p2;
  logic                done_q;

  // Mem1 decode: MSB selects sample vs coefficient, out-of-range indices dropped
  logic [LW-1:0] m1_low;
  logic          m1_wr;
  logic          coef_wr;
  logic          smp_wr;
  logic          unused_data;

  assign m1_low      = bus.Mem1_addrw_i[LW-1:0];
  assign m1_wr       = bus.Mem1_en_i & bus.Mem1_we_i;
  assign coef_wr     = m1_wr & ~bus.Mem1_addrw_i[MEM1_AW-1] & (int'(m1_low) < HARMONICS_NUM);
  assign smp_wr      = m1_wr &  bus.Mem1_addrw_i[MEM1_AW-1] & (int'(m1_low) < IN_SERIES_NUM);
  assign unused_data = ^bus.Mem1_data_i;

  always_ff @(posedge clk_i) begin
    if (coef_wr)
      coef_mem[m1_low[HW-1:0]] <= bus.Mem1_data_i[COEF_W-1:0];
    if (smp_wr)
      smp_mem[m1_low[CW-1:0]] <= bus.Mem1_data_i[DATA_W-1:0];
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      h_cnt    <= '0;
      ch_cnt   <= '0;
      dcnt     <= '0;
      init_q   <= 1'b1;
      enable_q <= 1'b0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      h_cnt    <= h_nxt;
      ch_cnt   <= ch_nxt;
      dcnt     <= dcnt_nxt;
      init_q   <= 1'b0;
      enable_q <= bus.enable_i;
      vld_p0   <= issue;
      vld_p1   <= vld_p0;
    end
  end

  // FSM next state. init_q forces the auto-clear on the first edge after
  // reset; clear beats a simultaneous enable edge. DRAIN holds for three
  // edges so done and the WIP drop line up one cycle after the last write.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    h_nxt     = h_cnt;
    ch_nxt    = ch_cnt;
    dcnt_nxt  = dcnt;
    done_nxt  = 1'b0;
    issue     = 1'b0;
    clr_wr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        h_nxt    = '0;
        ch_nxt   = '0;
        dcnt_nxt = '0;
        if (init_q || bus.clear_i)
          state_nxt = CLEAR;
        else if (bus.enable_i && !enable_q)
          state_nxt = RUN;
      end
      CLEAR: begin
        clr_wr  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == KW'(N - 1))
          state_nxt = IDLE;
      end
      RUN: begin
        issue   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (h_cnt == HW'(HARMONICS_NUM - 1)) begin
          h_nxt  = '0;
          ch_nxt = ch_cnt + 1'b1;
        end else begin
          h_nxt  = h_cnt + 1'b1;
        end
        if (cnt == KW'(N - 1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        dcnt_nxt = dcnt + 1'b1;
        if (dcnt == 2'd2) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 1: fetch state, coefficient and sample of element cnt ----
  always_ff @(posedge clk_i) begin
    s1_p0   <= s1_mem[cnt];
    s2_p0   <= s2_mem[cnt];
    coef_p0 <= coef_mem[h_cnt];
    x_p0    <= smp_mem[ch_cnt];
    k_p0    <= cnt;
  end

  // ---- stage 2: shared multiply and floor scaling ----
  assign prod_w = PW'(coef_p0) * PW'(s1_p0);

  always_ff @(posedge clk_i) begin
    psh_p1 <= scale_floor(prod_w);
    x_p1   <= x_p0;
    s1_p1  <= s1_p0;
    s2_p1  <= s2_p0;
    k_p1   <= k_p0;
  end

  // ---- stage 3: accumulate, saturate, write back and emit ----
  assign sum_w = SW'(x_p1) + psh_p1 - SW'(s2_p1);
  assign s0_w  = sat_state(sum_w);

  // Addresses within a run are distinct and a run never overlaps CLEAR,
  // so one write port per state RAM suffices.
  always_ff @(posedge clk_i) begin
    if (clr_wr) begin
      s1_mem[cnt] <= '0;
      s2_mem[cnt] <= '0;
    end else if (vld_p1) begin
      s1_mem[k_p1] <= s0_w;
      s2_mem[k_p1] <= s1_p1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_p2   <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
      done_q  <= 1'b0;
    end else begin
      we_p2  <= vld_p1;
      done_q <= done_nxt;
      if (vld_p1) begin
        addr_p2 <= MEM2_AW'(k_p1);
        data_p2 <= MEM2_DW'(s0_w);
      end
    end
  end

  assign bus.Mem2_we_o    = we_p2;
  assign bus.Mem2_addrw_o = addr_p2;
  assign bus.Mem2_data_o  = data_p2;
  assign bus.done_o       = done_q;
  assign bus.WIP_flag_o   = (state != IDLE);

endmodule

// File: tb/tb_resonant_bank.sv
`timescale 1ns/1ps
module tb_resonant_bank;
  localparam int H       = 26;
  localparam int CH      = 6;
  localparam int N       = H * CH;
  localparam int DATA_W  = 18;
  localparam int COEF_W  = 18;
  localparam int STATE_W = 20;
  localparam int MEM1_AW = 9;
  localparam int MEM2_AW = 9;
  localparam int MEM2_DW = 36;
  localparam longint SMAX = (64'sd1 <<< (STATE_W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (STATE_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  resonant_bank_if #(.MEM1_AW(MEM1_AW), .MEM2_AW(MEM2_AW), .MEM2_DW(MEM2_DW)) bus ();

  resonant_bank #(
    .HARMONICS_NUM(H), .IN_SERIES_NUM(CH), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .STATE_W(STATE_W), .MEM1_AW(MEM1_AW), .MEM2_AW(MEM2_AW), .MEM2_DW(MEM2_DW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  typedef struct {
    int     addr;
    longint data;
  } exp_t;

  exp_t   exp_q[$];
  longint addr0_log[$];
  longint m_s1[N];
  longint m_s2[N];
  longint m_coef[H];
  longint m_x[CH];
  int     checks = 0;
  int     errors = 0;

  // Reference model of one update run; pushes the expected result stream.
  function automatic void model_run();
    exp_t   e;
    longint p;
    longint s0;
    int     k;
    for (int ch = 0; ch < CH; ch++) begin
      for (int h = 0; h < H; h++) begin
        k  = ch * H + h;
        p  = (m_coef[h] * m_s1[k]) >>> (COEF_W - 2);
        s0 = m_x[ch] + p - m_s2[k];
        if (s0 > SMAX) s0 = SMAX;
        else if (s0 < SMIN) s0 = SMIN;
        m_s2[k] = m_s1[k];
        m_s1[k] = s0;
        e.addr = k;
        e.data = s0;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void model_zero();
    for (int k = 0; k < N; k++) begin
      m_s1[k] = 0;
      m_s2[k] = 0;
    end
  endfunction

  // Result monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.Mem2_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, no result expected",
                 bus.Mem2_addrw_o, $signed(bus.Mem2_data_o));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.Mem2_addrw_o !== MEM2_AW'(e.addr) ||
            longint'($signed(bus.Mem2_data_o)) !== e.data) begin
          errors++;
          $display("FAIL scoreboard: got addr %0d data %0d, expected addr %0d data %0d",
                   bus.Mem2_addrw_o, $signed(bus.Mem2_data_o), e.addr, e.data);
        end
      end
      if (bus.Mem2_addrw_o == '0)
        addr0_log.push_back(longint'($signed(bus.Mem2_data_o)));
    end
  end

  task automatic mem1_write(input bit smp, input int idx, input longint val);
    @(negedge clk);
    bus.Mem1_en_i    = 1'b1;
    bus.Mem1_we_i    = 1'b1;
    bus.Mem1_addrw_i = {smp, (MEM1_AW-1)'(idx)};
    bus.Mem1_data_i  = 32'(val);
    @(negedge clk);
    bus.Mem1_en_i    = 1'b0;
    bus.Mem1_we_i    = 1'b0;
  endtask

  task automatic set_coef(input int h, input longint v);
    mem1_write(1'b0, h, v);
    m_coef[h] = v;
  endtask

  task automatic set_sample(input int ch, input longint v);
    mem1_write(1'b1, ch, v);
    m_x[ch] = v;
  endtask

  task automatic set_all(input longint c, input longint x);
    for (int h = 0; h < H; h++) set_coef(h, c);
    for (int ch = 0; ch < CH; ch++) set_sample(ch, x);
  endtask

  // Counts cycles with WIP high starting at the next edge; bounded.
  task automatic measure_wip(output int n);
    n = 0;
    for (int i = 0; i < 2 * N + 10; i++) begin
      @(posedge clk);
      #1;
      bus.clear_i = 1'b0;
      if (bus.WIP_flag_o) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic run_once(input bit toggle_mid, input bit clear_mid, input string tag);
    int dones, done_cyc, n_we, first_we, last_we;
    model_run();
    @(negedge clk);
    checks++;
    if (bus.WIP_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL %s wip_before_start: got %b expected 0", tag, bus.WIP_flag_o);
    end
    bus.enable_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.WIP_flag_o !== 1'b1) begin
      errors++;
      $display("FAIL %s wip_after_start: got %b expected 1", tag, bus.WIP_flag_o);
    end
    dones = 0; done_cyc = -1; n_we = 0; first_we = -1; last_we = -1;
    for (int cyc = 1; cyc <= N + 20; cyc++) begin
      @(negedge clk);
      if (toggle_mid && cyc >= 12 && cyc < 20) bus.enable_i = 1'b1;
      else if (cyc >= 5) bus.enable_i = 1'b0;
      bus.clear_i = clear_mid && (cyc == 30);
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        dones++;
        done_cyc = cyc;
      end
      if (bus.Mem2_we_o) begin
        n_we++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", tag, dones);
    end
    checks++;
    if (done_cyc != N + 3) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected %0d", tag, done_cyc, N + 3);
    end
    checks++;
    if (n_we != N || first_we != 3 || last_we != N + 2) begin
      errors++;
      $display("FAIL %s write_window: got %0d writes cycles %0d..%0d expected %0d writes cycles 3..%0d",
               tag, n_we, first_we, last_we, N, N + 2);
    end
    checks++;
    if (bus.WIP_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL %s wip_after_done: got %b expected 0", tag, bus.WIP_flag_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_results: got %0d pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Mem2_we_o !== 1'b0 || bus.Mem2_addrw_o !== '0 || bus.Mem2_data_o !== '0 ||
        bus.done_o !== 1'b0 || bus.WIP_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got we %b addr %0d data %0d done %b wip %b expected all 0",
               bus.Mem2_we_o, bus.Mem2_addrw_o, bus.Mem2_data_o, bus.done_o, bus.WIP_flag_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    measure_wip(n);
    model_zero();
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL auto_clear_len: got %0d expected %0d", n, N);
    end
  endtask

  task automatic test_zero_run();
    set_all(0, 0);
    run_once(1'b0, 1'b0, "zero_run");
  endtask

  task automatic test_resonator();
    longint exp_a0[7] = '{1, 1, 0, -1, -1, 0, 1};
    set_coef(0, 65536);
    set_sample(0, 1);
    addr0_log.delete();
    run_once(1'b0, 1'b0, "resonator_1");
    set_sample(0, 0);
    for (int r = 2; r <= 7; r++) run_once(1'b0, 1'b0, "resonator");
    checks++;
    if (addr0_log.size() != 7) begin
      errors++;
      $display("FAIL resonator_len: got %0d expected 7", addr0_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (addr0_log[i] != exp_a0[i]) begin
          errors++;
          $display("FAIL resonator_seq[%0d]: got %0d expected %0d", i, addr0_log[i], exp_a0[i]);
        end
      end
    end
  endtask

  task automatic test_clear_idle(input string tag);
    int n;
    @(negedge clk);
    bus.clear_i = 1'b1;
    measure_wip(n);
    model_zero();
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL %s clear_len: got %0d expected %0d", tag, n, N);
    end
  endtask

  task automatic test_impulse_c0();
    longint exp_a0[3] = '{100, 100, 0};
    set_all(0, 100);
    addr0_log.delete();
    run_once(1'b0, 1'b0, "impulse_1");
    run_once(1'b0, 1'b0, "impulse_2");
    run_once(1'b0, 1'b1, "impulse_3_clear_mid");
    checks++;
    if (addr0_log.size() != 3) begin
      errors++;
      $display("FAIL impulse_len: got %0d expected 3", addr0_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr0_log[i] != exp_a0[i]) begin
          errors++;
          $display("FAIL impulse_seq[%0d]: got %0d expected %0d", i, addr0_log[i], exp_a0[i]);
        end
      end
    end
  endtask

  task automatic test_clear_then_run();
    test_clear_idle("clear_after_impulse");
    set_all(65536, 0);
    run_once(1'b0, 1'b0, "post_clear_zero");
  endtask

  task automatic test_saturation();
    bit neg;
    set_all(130000, 131071);
    addr0_log.delete();
    for (int r = 0; r < 5; r++) run_once(1'b0, 1'b0, "saturation");
    neg = 1'b0;
    foreach (addr0_log[i]) if (addr0_log[i] < 0) neg = 1'b1;
    checks++;
    if (addr0_log.size() != 5 || neg) begin
      errors++;
      $display("FAIL sat_no_wrap: got %0d entries negative=%b expected 5 entries negative=0",
               addr0_log.size(), neg);
    end else begin
      checks++;
      if (addr0_log[0] != 131071) begin
        errors++;
        $display("FAIL sat_first: got %0d expected 131071", addr0_log[0]);
      end
      checks++;
      if (addr0_log[4] != 524287) begin
        errors++;
        $display("FAIL sat_clamp: got %0d expected 524287", addr0_log[4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_all(65536, 7);
    run_once(1'b1, 1'b0, "mid_run_enable");
    run_once(1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_midrun();
    int n;
    model_run();
    @(negedge clk);
    bus.enable_i = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    #1;
    checks++;
    if (bus.Mem2_we_o !== 1'b0 || bus.Mem2_addrw_o !== '0 || bus.Mem2_data_o !== '0 ||
        bus.done_o !== 1'b0 || bus.WIP_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_values: got we %b addr %0d data %0d done %b wip %b expected all 0",
               bus.Mem2_we_o, bus.Mem2_addrw_o, bus.Mem2_data_o, bus.done_o, bus.WIP_flag_o);
    end
    exp_q.delete();
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    measure_wip(n);
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL midrun_auto_clear_len: got %0d expected %0d", n, N);
    end
    run_once(1'b0, 1'b0, "after_midrun_reset");
  endtask

  initial begin
    bus.Mem1_data_i  = '0;
    bus.Mem1_addrw_i = '0;
    bus.Mem1_en_i    = 1'b0;
    bus.Mem1_we_i    = 1'b0;
    bus.enable_i     = 1'b0;
    bus.clear_i      = 1'b0;
    test_reset();
    test_zero_run();
    test_resonator();
    test_clear_idle("clear_after_resonator");
    test_impulse_c0();
    test_clear_then_run();
    test_saturation();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
